pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_wdog.sv | 44 ++++
 rtl/pipe_ctrl.sv | 96 +++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared definitions for the pipeline controller.
//   Stall encodings (StallNone/StallId/StallEx/StallMem), per-bit hold
//   levels (Stop/NoStop), FSM state encoding and the stall priority
//   encoder used by pipe_ctrl.
package pipe_ctrl_pkg;

  // Per-stage hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
  // A request from a stage holds that stage and everything upstream of it.
  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallId   = 6'b000111;
  localparam logic [5:0] StallEx   = 6'b001111;
  localparam logic [5:0] StallMem  = 6'b011111;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  // The deepest requesting stage wins: mem > ex > id.
  function automatic logic [5:0] stall_encode(input logic mem, input logic ex,
                                              input logic id);
    if (mem == Stop) return StallMem;
    if (ex == Stop)  return StallEx;
    if (id == Stop)  return StallId;
    return StallNone;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- handshake bundle between the pipeline and pipe_ctrl.
//   Requests : stallreq_id/ex/mem, excp_req + excp_vector, eret_req + epc
//   Responses: stall[5:0], flush, new_pc[31:0], busy
//              wdog_err (only when PIPE_STALL_WDOG_EN is defined)
//   modport slave  : the controller side (requests in, responses out)
//   modport master : the pipeline side  (requests out, responses in)
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_vector;
  logic        eret_req;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
`ifdef PIPE_STALL_WDOG_EN
  logic        wdog_err;

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_vector,
           eret_req, epc,
    output stall, flush, new_pc, busy, wdog_err
  );
  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_vector,
           eret_req, epc,
    input  stall, flush, new_pc, busy, wdog_err
  );
`else
  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_vector,
           eret_req, epc,
    output stall, flush, new_pc, busy
  );
  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_vector,
           eret_req, epc,
    input  stall, flush, new_pc, busy
  );
`endif
endinterface

// File: rtl/pipe_wdog.sv
// pipe_wdog -- PC-stall watchdog (built only with PIPE_STALL_WDOG_EN).
//   clk        : clock
//   rst        : asynchronous active-low reset
//   stall_pc_i : stall[0], the PC hold bit
//   wdog_err_o : sticky error, set once the PC has been held WDOG_LIMIT
//                consecutive cycles; cleared only by reset
module pipe_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int WDOG_LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_pc_i,
  output logic wdog_err_o
);

  localparam logic [15:0] Limit = 16'(WDOG_LIMIT);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  always_comb begin
    cnt_d = '0;
    if (stall_pc_i == Stop) begin
      // Saturate so a very long stall cannot wrap back below the limit.
      cnt_d = (cnt_q >= Limit) ? Limit : cnt_q + 16'd1;
    end
    err_d = err_q | (cnt_d == Limit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign wdog_err_o = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall/flush controller.
//   clk : clock, all state on its rising edge
//   rst : asynchronous active-low reset
//   bus : pipe_ctrl_if.slave (stall requests, exception/eret redirects in;
//         stall vector, flush pulse, new_pc, busy out)
// Parameters: REFILL_CYCLES (1..15) cycles spent in REFILL after a flush,
//             WDOG_LIMIT (1..65535) watchdog trip point.
// Optional feature: define PIPE_STALL_WDOG_EN to add the pipe_wdog
// PC-stall watchdog and the bus.wdog_err output.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REFILL_CYCLES = 2,
  parameter int WDOG_LIMIT    = 1023
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [3:0]  refill_q, refill_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  stall_c;

  always_comb begin
    state_d  = state_q;
    refill_d = refill_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    stall_c  = StallNone;
    case (state_q)
      ST_FLUSH: begin
        // Requests arriving during the kill cycle are deliberately ignored.
        state_d  = ST_REFILL;
        refill_d = 4'(REFILL_CYCLES - 1);
      end
      ST_IDLE, ST_REFILL: begin
        stall_c = stall_encode(bus.stallreq_mem, bus.stallreq_ex,
                               bus.stallreq_id);
        if (bus.excp_req) begin
          // Exception beats a simultaneous eret; the eret is simply lost.
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = bus.excp_vector;
        end else if (bus.eret_req) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = bus.epc;
        end else if (state_q == ST_REFILL) begin
          // Stalls do not pause the refill countdown.
          if (refill_q == 4'd0) state_d = ST_IDLE;
          else                  refill_d = refill_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      refill_q <= '0;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // stall is combinational from the requests, so it must be gated by reset
  // explicitly; the registered outputs are already cleared asynchronously.
  assign bus.stall  = rst ? stall_c : StallNone;
  assign bus.flush  = flush_q;
  assign bus.new_pc = new_pc_q;
  assign bus.busy   = (state_q != ST_IDLE);

`ifdef PIPE_STALL_WDOG_EN
  pipe_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .stall_pc_i(bus.stall[0]),
    .wdog_err_o(bus.wdog_err)
  );
`else
  logic [15:0] unused_wdog_limit;
  assign unused_wdog_limit = 16'(WDOG_LIMIT);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl
// (REFILL_CYCLES=2, WDOG_LIMIT=4). Inputs change just after the falling
// edge; outputs are sampled on the falling edge or shortly after an input
// change for the combinational stall path.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus_if ();

  pipe_ctrl #(
    .REFILL_CYCLES(2),
    .WDOG_LIMIT   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic clear_reqs();
    bus_if.stallreq_id  = 1'b0;
    bus_if.stallreq_ex  = 1'b0;
    bus_if.stallreq_mem = 1'b0;
    bus_if.excp_req     = 1'b0;
    bus_if.eret_req     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_reqs();
    bus_if.excp_vector = 32'h0;
    bus_if.epc         = 32'h0;

    // Reset state, with a stall request present to prove stall is gated.
    bus_if.stallreq_mem = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_stall",  32'(bus_if.stall), 32'h00);
    check("rst_busy",   32'(bus_if.busy), 32'h0);
    check("rst_flush",  32'(bus_if.flush), 32'h0);
    check("rst_new_pc", bus_if.new_pc, 32'h0);
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);

    // ID stall for three cycles.
    bus_if.stallreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("id_stall_c%0d", i), 32'(bus_if.stall), 32'h07);
      check($sformatf("id_flush_c%0d", i), 32'(bus_if.flush), 32'h0);
      @(negedge clk);
    end
    bus_if.stallreq_id = 1'b0;
    #1 check("id_release", 32'(bus_if.stall), 32'h00);

    // Priority mem > ex > id, combinational.
    bus_if.stallreq_id = 1'b1; bus_if.stallreq_ex = 1'b1; bus_if.stallreq_mem = 1'b1;
    #1 check("prio_all", 32'(bus_if.stall), 32'h1F);
    bus_if.stallreq_mem = 1'b0;
    #1 check("prio_ex_id", 32'(bus_if.stall), 32'h0F);
    bus_if.stallreq_ex = 1'b0;
    #1 check("prio_id", 32'(bus_if.stall), 32'h07);
    clear_reqs();
    @(negedge clk);

    // Exception: flush timing, busy window, stall gated in FLUSH only.
    bus_if.excp_req = 1'b1; bus_if.excp_vector = 32'hBFC00380;
    #1 check("excp_n_busy", 32'(bus_if.busy), 32'h0);
    @(negedge clk);
    bus_if.excp_req = 1'b0; bus_if.stallreq_id = 1'b1;
    #1;
    check("excp_n1_flush",  32'(bus_if.flush), 32'h1);
    check("excp_n1_new_pc", bus_if.new_pc, 32'hBFC00380);
    check("excp_n1_stall",  32'(bus_if.stall), 32'h00);
    check("excp_n1_busy",   32'(bus_if.busy), 32'h1);
    @(negedge clk); #1;
    check("excp_n2_flush",  32'(bus_if.flush), 32'h0);
    check("excp_n2_busy",   32'(bus_if.busy), 32'h1);
    check("excp_n2_stall",  32'(bus_if.stall), 32'h07);
    check("excp_n2_new_pc", bus_if.new_pc, 32'hBFC00380);
    @(negedge clk); #1;
    check("excp_n3_busy",   32'(bus_if.busy), 32'h1);
    check("excp_n3_stall",  32'(bus_if.stall), 32'h07);
    @(negedge clk); #1;
    check("excp_n4_busy",   32'(bus_if.busy), 32'h0);
    clear_reqs();
    @(negedge clk);

    // Exception and eret together; excp still high during FLUSH.
    bus_if.excp_req = 1'b1; bus_if.eret_req = 1'b1;
    bus_if.excp_vector = 32'h80000180; bus_if.epc = 32'h00400010;
    @(negedge clk);
    check("both_flush",  32'(bus_if.flush), 32'h1);
    check("both_new_pc", bus_if.new_pc, 32'h80000180);
    @(negedge clk);
    clear_reqs();
    check("both_no_2nd_flush", 32'(bus_if.flush), 32'h0);
    check("both_refill_busy",  32'(bus_if.busy), 32'h1);
    @(negedge clk);
    check("both_r2_flush", 32'(bus_if.flush), 32'h0);
    @(negedge clk);
    check("both_idle", 32'(bus_if.busy), 32'h0);

    // eret alone, then an exception accepted from REFILL.
    bus_if.eret_req = 1'b1;
    @(negedge clk);
    bus_if.eret_req = 1'b0;
    check("eret_flush",  32'(bus_if.flush), 32'h1);
    check("eret_new_pc", bus_if.new_pc, 32'h00400010);
    @(negedge clk);
    bus_if.excp_req = 1'b1; bus_if.excp_vector = 32'h12345678;
    @(negedge clk);
    bus_if.excp_req = 1'b0;
    check("refill_excp_flush",  32'(bus_if.flush), 32'h1);
    check("refill_excp_new_pc", bus_if.new_pc, 32'h12345678);
    repeat (3) @(negedge clk);
    check("refill_excp_idle", 32'(bus_if.busy), 32'h0);

    // Asynchronous reset mid-REFILL with a mem stall pending.
    bus_if.excp_req = 1'b1;
    @(negedge clk);
    bus_if.excp_req = 1'b0;
    @(negedge clk);
    bus_if.stallreq_mem = 1'b1;
    #1;
    check("arst_pre_stall", 32'(bus_if.stall), 32'h1F);
    check("arst_pre_busy",  32'(bus_if.busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_stall",  32'(bus_if.stall), 32'h00);
    check("arst_busy",   32'(bus_if.busy), 32'h0);
    check("arst_flush",  32'(bus_if.flush), 32'h0);
    check("arst_new_pc", bus_if.new_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus_if.stallreq_mem = 1'b0;
    @(negedge clk);
    check("arst_after_busy",  32'(bus_if.busy), 32'h0);
    check("arst_after_flush", 32'(bus_if.flush), 32'h0);

`ifdef PIPE_STALL_WDOG_EN
    // Watchdog trips after 4 consecutive PC-hold cycles and sticks.
    check("wdog_init", 32'(bus_if.wdog_err), 32'h0);
    bus_if.stallreq_ex = 1'b1;
    repeat (3) @(negedge clk);
    check("wdog_3cyc", 32'(bus_if.wdog_err), 32'h0);
    @(negedge clk);
    check("wdog_4cyc", 32'(bus_if.wdog_err), 32'h1);
    bus_if.stallreq_ex = 1'b0;
    repeat (3) @(negedge clk);
    check("wdog_sticky", 32'(bus_if.wdog_err), 32'h1);
    rst = 1'b0;
    #1 check("wdog_rst", 32'(bus_if.wdog_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
